// File: rtl/detector_window_reader.sv
// detector_window_reader: synchronizes asynchronous detector levels, ORs them over a
// window of 1+WINDOW_LENGTH samples opened by the first nonzero sample, and emits the
// closed window as a single-entry AXI-Stream snapshot.
// Optional build macro: DETECTOR_READER_DROP_CNT_EN adds a saturating drop_count output.
module detector_window_reader #(
    parameter int unsigned DET_WIDTH     = 64,
    parameter int unsigned GROUP_COUNT   = 4,
    parameter int unsigned WINDOW_LENGTH = 16,
    parameter int unsigned SYNC_STAGES   = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DET_WIDTH-1:0]   det_data,
    output logic [GROUP_COUNT-1:0] grp_data,
    output logic                   busy,
    output logic [DET_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
`ifdef DETECTOR_READER_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam int unsigned GW = DET_WIDTH / GROUP_COUNT;
    localparam int unsigned CW = (WINDOW_LENGTH > 1) ? $clog2(WINDOW_LENGTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WINDOW_LENGTH - 1);

    typedef enum logic {
        StIdle,
        StAccum
    } state_t;

    logic [DET_WIDTH-1:0] r_sync [SYNC_STAGES];
    state_t               r_state;
    logic [DET_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic [DET_WIDTH-1:0] r_tdata;
    logic                 r_tvalid;

    logic [DET_WIDTH-1:0]   w_s;
    logic [DET_WIDTH-1:0]   w_merged;
    logic                   w_close;
    logic                   w_load;
    logic [GROUP_COUNT-1:0] w_grp;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_merged = r_acc | w_s;
    assign w_close  = (r_state == StAccum) && (r_cnt == C_LAST);
    // A closing window may only take the output slot if it is free or being drained now.
    assign w_load   = w_close && (!r_tvalid || m_axis_tready);

    // Multi-stage synchronizer per detector bit.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= det_data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Window FSM: idle tracks the live sample, accum ORs samples until the count expires.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_acc <= w_s;
                    r_cnt <= '0;
                    if (|w_s) begin
                        r_state <= StAccum;
                    end
                end
                StAccum: begin
                    r_acc <= w_merged;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Single-entry output register; a new snapshot may replace one accepted on the same edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_merged;
        end else if (r_tvalid && m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    // Per-group OR of the registered accumulator.
    always_comb begin
        w_grp = '0;
        for (int g = 0; g < int'(GROUP_COUNT); g++) begin
            w_grp[g] = |r_acc[g*GW +: GW];
        end
    end

    assign grp_data      = w_grp;
    assign busy          = (r_state == StAccum);
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;

`ifdef DETECTOR_READER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_close && !w_load;

    // Saturating count of windows lost because the output slot was still occupied.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule
